// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_bus_pkg
//  Description : Shared NES CPU-bus constants and the OAM DMA state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package nes_bus_pkg;

    // CPU write to this address starts a sprite DMA; data byte is the source page
    localparam logic [15:0] ADDR_OAMDMA   = 16'h4014;
    // PPU OAMDATA port, destination of every DMA write cycle
    localparam logic [15:0] ADDR_OAMDATA  = 16'h2004;
    // sys_clk cycles per CPU cycle; the clock generator uses it to build cpu_ce
    localparam int          CPU_CYCLE_DIV = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : Sprite OAM DMA sequencer. On a CPU write to $4014 it stalls
//                the CPU through RDY, takes the bus and copies one page to
//                OAMDATA as alternating read/write CPU cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int          XFER_LEN      = 256
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        i_cpu_ce,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_dout,
    input  logic        i_cpu_we,
    input  logic [7:0]  i_bus_rdata,
    output logic        o_dma_rdy,
    output logic        o_dma_active,
    output logic [15:0] o_dma_addr,
    output logic [7:0]  o_dma_wdata,
    output logic        o_dma_we,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    output logic        o_bus_we
);

    // Index of the final byte; idx is 8 bits so {page,idx} never carries
    localparam logic [7:0] c_LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  r_state, w_nxt_state;
    logic [7:0]  r_page,  w_nxt_page;
    logic [7:0]  r_idx,   w_nxt_idx;
    logic        r_par,   w_nxt_par;
    logic        r_rdy,   w_nxt_rdy;
    logic        r_active, w_nxt_active;
    logic [15:0] r_addr,  w_nxt_addr;
    logic [7:0]  r_wdata, w_nxt_wdata;
    logic        r_we,    w_nxt_we;

    // Next-state and next-output values; registered outputs describe the state being entered
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_page   = r_page;
        w_nxt_idx    = r_idx;
        w_nxt_par    = ~r_par;
        w_nxt_rdy    = r_rdy;
        w_nxt_active = r_active;
        w_nxt_addr   = r_addr;
        w_nxt_wdata  = r_wdata;
        w_nxt_we     = r_we;
        case (r_state)
            IDLE: begin
                if (i_cpu_we && (i_cpu_addr == DMA_REG_ADDR)) begin
                    w_nxt_state = HALT;
                    w_nxt_page  = i_cpu_dout;
                    w_nxt_rdy   = 1'b0;
                end
            end
            HALT: begin
                // RDY only stalls the 6502 on a read, so wait for one
                if (!i_cpu_we) begin
                    w_nxt_active = 1'b1;
                    w_nxt_we     = 1'b0;
                    if (w_nxt_par) begin
                        w_nxt_state = ALIGN;
                    end else begin
                        w_nxt_state = READ;
                        w_nxt_addr  = {r_page, r_idx};
                    end
                end
            end
            ALIGN: begin
                w_nxt_state = READ;
                w_nxt_addr  = {r_page, r_idx};
                w_nxt_we    = 1'b0;
            end
            READ: begin
                w_nxt_state = WRITE;
                w_nxt_wdata = i_bus_rdata;
                w_nxt_addr  = OAM_DATA_ADDR;
                w_nxt_we    = 1'b1;
            end
            WRITE: begin
                w_nxt_we = 1'b0;
                if (r_idx == c_LAST_IDX) begin
                    w_nxt_state  = IDLE;
                    w_nxt_rdy    = 1'b1;
                    w_nxt_active = 1'b0;
                    w_nxt_idx    = 8'd0;
                end else begin
                    w_nxt_state = READ;
                    w_nxt_idx   = r_idx + 8'd1;
                    w_nxt_addr  = {r_page, r_idx + 8'd1};
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State and output registers advance only on CPU-cycle strobes
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_page   <= 8'd0;
            r_idx    <= 8'd0;
            r_par    <= 1'b0;
            r_rdy    <= 1'b1;
            r_active <= 1'b0;
            r_addr   <= 16'd0;
            r_wdata  <= 8'd0;
            r_we     <= 1'b0;
        end else if (i_cpu_ce) begin
            r_state  <= w_nxt_state;
            r_page   <= w_nxt_page;
            r_idx    <= w_nxt_idx;
            r_par    <= w_nxt_par;
            r_rdy    <= w_nxt_rdy;
            r_active <= w_nxt_active;
            r_addr   <= w_nxt_addr;
            r_wdata  <= w_nxt_wdata;
            r_we     <= w_nxt_we;
        end
    end

    assign o_dma_rdy    = r_rdy;
    assign o_dma_active = r_active;
    assign o_dma_addr   = r_addr;
    assign o_dma_wdata  = r_wdata;
    assign o_dma_we     = r_we;

    // Bus ownership mux in front of the RAM/PPU/PRG decoder
    assign o_bus_addr  = r_active ? r_addr  : i_cpu_addr;
    assign o_bus_wdata = r_active ? r_wdata : i_cpu_dout;
    assign o_bus_we    = r_active ? r_we    : i_cpu_we;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma_ctrl
//  Description : Self-checking bench for oam_dma_ctrl with a memory pattern
//                model and a scoreboard of expected OAM writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oam_dma_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        cpu_ce  = 1'b0;
    logic [15:0] cpu_addr = 16'd0;
    logic [7:0]  cpu_dout = 8'd0;
    logic        cpu_we   = 1'b0;
    logic [7:0]  bus_rdata;
    logic        o_dma_rdy, o_dma_active, o_dma_we, o_bus_we;
    logic [15:0] o_dma_addr, o_bus_addr;
    logic [7:0]  o_dma_wdata, o_bus_wdata;

    oam_dma_ctrl dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .i_cpu_ce     (cpu_ce),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_dout   (cpu_dout),
        .i_cpu_we     (cpu_we),
        .i_bus_rdata  (bus_rdata),
        .o_dma_rdy    (o_dma_rdy),
        .o_dma_active (o_dma_active),
        .o_dma_addr   (o_dma_addr),
        .o_dma_wdata  (o_dma_wdata),
        .o_dma_we     (o_dma_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_we     (o_bus_we)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory contents as a function of address
    function automatic logic [7:0] pat(input logic [15:0] a);
        return (a[7:0] ^ 8'hA5) + a[15:8];
    endfunction

    always_comb bus_rdata = pat(o_bus_addr);

    int          errors = 0;
    int          checks = 0;
    int          rdy_low = 0;
    int          n_wr = 0;
    logic        m_busy = 1'b0;
    logic        m_par  = 1'b0;
    logic [15:0] last_rd = 16'd0;
    logic [7:0]  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Looks at the outputs in force during the CPU cycle that is about to end
    task automatic observe();
        if (!o_dma_rdy) rdy_low++;
        if (o_dma_active && !o_dma_we) last_rd = o_dma_addr;
        if (o_dma_active && o_dma_we) begin
            n_wr++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {16'd0, o_dma_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("wr_addr", {16'd0, o_dma_addr}, {16'd0, 16'h2004});
                chk("wr_data", {24'd0, o_dma_wdata}, {24'd0, e});
                if (sb.size() == 0) m_busy = 1'b0;
            end
        end
    endtask

    // One CPU cycle: two idle sys_clk, then a sys_clk with cpu_ce high
    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we);
        repeat (2) @(negedge sys_clk);
        cpu_addr = a; cpu_dout = d; cpu_we = we; cpu_ce = 1'b1;
        observe();
        if (!m_busy && we && a == 16'h4014) begin
            m_busy = 1'b1;
            for (int i = 0; i < 256; i++) sb.push_back(pat({d, 8'(i)}));
        end
        m_par = ~m_par;
        @(negedge sys_clk);
        cpu_ce = 1'b0;
    endtask

    task automatic align_parity(input logic want);
        if (m_par != want) cyc(16'h8000, 8'h00, 1'b0);
    endtask

    task automatic trigger(input logic [7:0] page);
        rdy_low = 0; n_wr = 0;
        cyc(16'h4014, page, 1'b1);
    endtask

    task automatic finish_xfer(input string name, input int exp_low);
        int k;
        k = 0;
        while (!(!m_busy && o_dma_rdy) && k < 700) begin
            cyc(16'h8010, 8'h00, 1'b0);
            k++;
        end
        if (k >= 700) chk({name, "_timeout"}, 32'd0, 32'd1);
        chk({name, "_rdy_low"}, rdy_low, exp_low);
        chk({name, "_nwr"}, n_wr, 256);
        chk({name, "_idle"}, {30'd0, o_dma_rdy, o_dma_active}, 32'd2);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_rdy"},   {31'd0, o_dma_rdy},    32'd1);
        chk({name, "_act"},   {31'd0, o_dma_active}, 32'd0);
        chk({name, "_we"},    {31'd0, o_dma_we},     32'd0);
        chk({name, "_addr"},  {16'd0, o_dma_addr},   32'd0);
        chk({name, "_wdata"}, {24'd0, o_dma_wdata},  32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        e_rdy;
        logic        e_act;
        logic        e_we;
        logic [15:0] e_addr;
        logic        chk_addr;
    } vec_t;

    vec_t vt[7];

    initial begin
        // Even-parity start, first cycles stepped explicitly
        vt[0] = '{16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[1] = '{16'h8001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[2] = '{16'h4014, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[3] = '{16'h8002, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b1};
        vt[4] = '{16'h8002, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2004, 1'b1};
        vt[5] = '{16'h8002, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0201, 1'b1};
        vt[6] = '{16'h8002, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2004, 1'b1};

        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        chk_reset_vals("reset");

        // Test 1: even start
        rdy_low = 0; n_wr = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].a, vt[i].d, vt[i].we);
            chk($sformatf("vec%0d_rdy", i), {31'd0, o_dma_rdy},    {31'd0, vt[i].e_rdy});
            chk($sformatf("vec%0d_act", i), {31'd0, o_dma_active}, {31'd0, vt[i].e_act});
            chk($sformatf("vec%0d_we", i),  {31'd0, o_dma_we},     {31'd0, vt[i].e_we});
            if (vt[i].chk_addr) begin
                chk($sformatf("vec%0d_addr", i), {16'd0, o_dma_addr}, {16'd0, vt[i].e_addr});
                chk($sformatf("vec%0d_busmux", i), {16'd0, o_bus_addr}, {16'd0, vt[i].e_addr});
            end
        end
        finish_xfer("even", 513);

        // Test 2: odd start adds one alignment cycle
        align_parity(1'b1);
        trigger(8'h02);
        finish_xfer("odd", 514);

        // Test 3: CPU still writing after the trigger
        align_parity(1'b0);
        trigger(8'h04);
        cyc(16'h0300, 8'h11, 1'b1);
        chk("midwr1_state", {30'd0, o_dma_rdy, o_dma_active}, 32'd0);
        cyc(16'h0301, 8'h22, 1'b1);
        chk("midwr2_state", {30'd0, o_dma_rdy, o_dma_active}, 32'd0);
        chk("midwr2_buswe", {31'd0, o_bus_we}, 32'd1);
        finish_xfer("midwr", 515);

        // Test 4: page $FF ends at $FFFF without wrapping
        align_parity(1'b0);
        trigger(8'hFF);
        finish_xfer("pageff", 513);
        chk("pageff_last_rd", {16'd0, last_rd}, {16'd0, 16'hFFFF});

        // Test 6: re-trigger ignored, ce gap holds everything
        align_parity(1'b0);
        trigger(8'h05);
        for (int k = 0; k < 40 && n_wr < 10; k++) cyc(16'h8020, 8'h00, 1'b0);
        cyc(16'h4014, 8'h77, 1'b1);
        if (!(o_dma_active && !o_dma_we)) cyc(16'h8020, 8'h00, 1'b0);
        begin
            logic [15:0] hold_addr;
            hold_addr = o_dma_addr;
            for (int k = 0; k < 20; k++) begin
                @(negedge sys_clk);
                cpu_addr = 16'h4014; cpu_we = k[0]; cpu_dout = 8'($urandom);
            end
            chk("gap_addr", {16'd0, o_dma_addr}, {16'd0, hold_addr});
            chk("gap_state", {29'd0, o_dma_rdy, o_dma_active, o_dma_we}, 32'd2);
        end
        finish_xfer("retrig", 513);

        // Test 5: reset at the 100th write cycle
        align_parity(1'b0);
        trigger(8'h06);
        for (int k = 0; k < 400 && !(n_wr == 99 && o_dma_we); k++) cyc(16'h8030, 8'h00, 1'b0);
        chk("rst_reached_wr100", {31'd0, o_dma_we}, 32'd1);
        rst = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0; cpu_ce = 1'b0;
        chk_reset_vals("midrst");
        sb.delete(); m_busy = 1'b0; m_par = 1'b0;
        trigger(8'h03);
        finish_xfer("after_rst", 513);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
